// File: rtl/axi4_wr_slave_ep_if.sv
// AXI4 write-path channel bundle (AW, W, B) between a write master and slave.
interface axi4_wr_slave_ep_if #(
    parameter int ID_WIDTH   = 4,
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 64,
    parameter int USER_WIDTH = 1
);
    logic [ID_WIDTH-1:0]     aw_id;
    logic [ADDR_WIDTH-1:0]   aw_addr;
    logic [7:0]              aw_len;
    logic [2:0]              aw_size;
    logic [1:0]              aw_burst;
    logic                    aw_valid;
    logic                    aw_ready;

    logic [DATA_WIDTH-1:0]   w_data;
    logic [DATA_WIDTH/8-1:0] w_strb;
    logic                    w_last;
    logic                    w_valid;
    logic                    w_ready;

    logic [ID_WIDTH-1:0]     b_id;
    logic [1:0]              b_resp;
    logic [USER_WIDTH-1:0]   b_user;
    logic                    b_valid;
    logic                    b_ready;

    modport master (
        output aw_id, aw_addr, aw_len, aw_size, aw_burst, aw_valid,
        input  aw_ready,
        output w_data, w_strb, w_last, w_valid,
        input  w_ready,
        input  b_id, b_resp, b_user, b_valid,
        output b_ready
    );

    modport slave (
        input  aw_id, aw_addr, aw_len, aw_size, aw_burst, aw_valid,
        output aw_ready,
        input  w_data, w_strb, w_last, w_valid,
        output w_ready,
        output b_id, b_resp, b_user, b_valid,
        input  b_ready
    );
endinterface

// File: rtl/axi4_wr_slave_ep.sv
// AXI4 write slave endpoint: queues AW, turns W beats into registered
// memory writes and returns one B response per burst.
module axi4_wr_slave_ep #(
    parameter int ID_WIDTH   = 4,
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 64,
    parameter int USER_WIDTH = 1,
    parameter int AW_DEPTH   = 4
) (
    input  logic                    aclk,
    input  logic                    arst,
    axi4_wr_slave_ep_if.slave       axi,
    output logic                    mem_we,
    output logic [ADDR_WIDTH-1:0]   mem_addr,
    output logic [DATA_WIDTH-1:0]   mem_wdata,
    output logic [DATA_WIDTH/8-1:0] mem_wstrb
);
    localparam int STRB_W   = DATA_WIDTH / 8;
    localparam int SIZE_MAX = $clog2(STRB_W);
    localparam int PTR_W    = $clog2(AW_DEPTH);
    localparam int ENT_W    = ID_WIDTH + ADDR_WIDTH + 8 + 3 + 2;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_DATA = 2'd1;
    localparam logic [1:0] ST_RESP = 2'd2;

    localparam logic [1:0] BT_FIXED = 2'b00;
    localparam logic [1:0] BT_WRAP  = 2'b10;
    localparam logic [1:0] BT_RSVD  = 2'b11;

    localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK = ~ADDR_WIDTH'(STRB_W - 1);

    logic [ENT_W-1:0]      q_mem [AW_DEPTH];
    logic [PTR_W-1:0]      wr_ptr;
    logic [PTR_W-1:0]      rd_ptr;
    logic [PTR_W:0]        count;
    logic                  full;
    logic                  push;
    logic                  pop;

    logic [ID_WIDTH-1:0]   h_id;
    logic [ADDR_WIDTH-1:0] h_addr;
    logic [7:0]            h_len;
    logic [2:0]            h_size;
    logic [1:0]            h_burst;
    logic                  pop_err;

    logic [1:0]            state;
    logic [ID_WIDTH-1:0]   cur_id;
    logic [ADDR_WIDTH-1:0] cur_addr;
    logic [7:0]            cur_len;
    logic [2:0]            cur_size;
    logic [1:0]            cur_burst;
    logic [7:0]            beat;
    logic                  err;

    logic [ADDR_WIDTH-1:0] step;
    logic [ADDR_WIDTH-1:0] wmask;
    logic [ADDR_WIDTH-1:0] incr_addr;
    logic [ADDR_WIDTH-1:0] next_addr;
    logic                  w_hs;
    logic                  at_end;

    logic                  mem_we_q;
    logic [ADDR_WIDTH-1:0] mem_addr_q;
    logic [DATA_WIDTH-1:0] mem_wdata_q;
    logic [STRB_W-1:0]     mem_wstrb_q;

    assign full = (count == (PTR_W + 1)'(AW_DEPTH));
    assign push = axi.aw_valid && axi.aw_ready;
    assign pop  = (state == ST_IDLE) && (count != '0);

    assign {h_id, h_addr, h_len, h_size, h_burst} = q_mem[rd_ptr];

    // Errors known at pop time suppress every memory write of the burst
    assign pop_err = (h_size > 3'(SIZE_MAX))
                   || (h_burst == BT_RSVD)
                   || ((h_burst == BT_WRAP)
                       && !(h_len inside {8'd1, 8'd3, 8'd7, 8'd15}));

    always_ff @(posedge aclk) begin
        if (push) begin
            q_mem[wr_ptr] <= {axi.aw_id, axi.aw_addr, axi.aw_len,
                              axi.aw_size, axi.aw_burst};
        end
    end

    always_ff @(posedge aclk) begin
        if (arst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            if (push && !pop)      count <= count + (PTR_W + 1)'(1);
            else if (pop && !push) count <= count - (PTR_W + 1)'(1);
        end
    end

    assign step      = ADDR_WIDTH'(1) << cur_size;
    assign wmask     = ((ADDR_WIDTH'(cur_len) + ADDR_WIDTH'(1)) << cur_size)
                     - ADDR_WIDTH'(1);
    assign incr_addr = cur_addr + step;

    always_comb begin
        next_addr = incr_addr;
        unique case (1'b1)
            (cur_burst == BT_FIXED): next_addr = cur_addr;
            (cur_burst == BT_WRAP):
                next_addr = (cur_addr & ~wmask) | (incr_addr & wmask);
            default: next_addr = incr_addr;
        endcase
    end

    assign w_hs   = (state == ST_DATA) && axi.w_valid;
    assign at_end = (beat == cur_len);

    always_ff @(posedge aclk) begin
        if (arst) begin
            state       <= ST_IDLE;
            cur_id      <= '0;
            cur_addr    <= '0;
            cur_len     <= '0;
            cur_size    <= '0;
            cur_burst   <= '0;
            beat        <= '0;
            err         <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            mem_wstrb_q <= '0;
        end else begin
            mem_we_q <= 1'b0;
            unique case (state)
                ST_IDLE: begin
                    if (pop) begin
                        cur_id    <= h_id;
                        cur_addr  <= h_addr;
                        cur_len   <= h_len;
                        cur_size  <= h_size;
                        cur_burst <= h_burst;
                        beat      <= '0;
                        err       <= pop_err;
                        state     <= ST_DATA;
                    end
                end
                ST_DATA: begin
                    if (w_hs) begin
                        mem_addr_q  <= cur_addr & ALIGN_MASK;
                        mem_wdata_q <= axi.w_data;
                        mem_wstrb_q <= axi.w_strb;
                        mem_we_q    <= !err;
                        cur_addr    <= next_addr;
                        beat        <= beat + 8'd1;
                        // Burst closes on whichever of WLAST or the length comes first
                        if (axi.w_last || at_end) begin
                            state <= ST_RESP;
                            if (axi.w_last != at_end) err <= 1'b1;
                        end
                    end
                end
                ST_RESP: begin
                    if (axi.b_ready) state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign axi.aw_ready = !arst && !full;
    assign axi.w_ready  = !arst && (state == ST_DATA);
    assign axi.b_valid  = !arst && (state == ST_RESP);
    assign axi.b_id     = arst ? '0 : cur_id;
    assign axi.b_resp   = (!arst && err) ? 2'b10 : 2'b00;
    assign axi.b_user   = '0;

    assign mem_we    = !arst && mem_we_q;
    assign mem_addr  = arst ? '0 : mem_addr_q;
    assign mem_wdata = arst ? '0 : mem_wdata_q;
    assign mem_wstrb = arst ? '0 : mem_wstrb_q;
endmodule

// File: tb/tb_axi4_wr_slave_ep.sv
// Randomized scoreboard bench for axi4_wr_slave_ep with a burst-level
// reference model computing expected memory writes and B responses.
module tb_axi4_wr_slave_ep;
    localparam int IDW   = 4;
    localparam int AWD   = 32;
    localparam int DW    = 64;
    localparam int UW    = 1;
    localparam int DEPTH = 4;
    localparam int SW    = DW / 8;

    typedef struct {
        logic [IDW-1:0] id;
        logic [AWD-1:0] addr;
        logic [7:0]     len;
        logic [2:0]     size;
        logic [1:0]     burst;
    } aw_t;

    typedef struct {
        logic [DW-1:0] data;
        logic [SW-1:0] strb;
        logic          last;
    } w_t;

    typedef struct {
        logic [AWD-1:0] addr;
        logic [DW-1:0]  data;
        logic [SW-1:0]  strb;
        logic           last;
    } mem_t;

    typedef struct {
        logic [IDW-1:0] id;
        logic [1:0]     resp;
    } b_t;

    logic aclk = 1'b0;
    logic arst;
    logic           mem_we;
    logic [AWD-1:0] mem_addr;
    logic [DW-1:0]  mem_wdata;
    logic [SW-1:0]  mem_wstrb;

    aw_t  aw_q[$];
    w_t   w_q[$];
    mem_t exp_mem[$];
    b_t   exp_b[$];

    int vectors    = 0;
    int miscompares = 0;
    bit w_hold = 1'b0;
    bit b_hold = 1'b0;

    always #5 aclk = ~aclk;

    axi4_wr_slave_ep_if #(
        .ID_WIDTH(IDW), .ADDR_WIDTH(AWD), .DATA_WIDTH(DW), .USER_WIDTH(UW)
    ) bus ();

    axi4_wr_slave_ep #(
        .ID_WIDTH(IDW), .ADDR_WIDTH(AWD), .DATA_WIDTH(DW),
        .USER_WIDTH(UW), .AW_DEPTH(DEPTH)
    ) dut (
        .aclk      (aclk),
        .arst      (arst),
        .axi       (bus),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_wstrb (mem_wstrb)
    );

    task automatic check(input string name, input logic [DW-1:0] act,
                         input logic [DW-1:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name);
        vectors++;
        miscompares++;
        $display("FAIL %s: bound expired, got timeout expected completion", name);
    endtask

    // Reference model: expected writes and response derived from AXI rules
    task automatic send_burst(input logic [IDW-1:0] id, input longint unsigned addr,
                              input int len, input int size, input int burst,
                              input int nbeats, input bit last_on_end);
        aw_t a;
        w_t  w;
        mem_t m;
        b_t  b;
        bit err0;
        bit mismatch;
        longint unsigned bytes, wsize, base, ba;
        a.id = id; a.addr = AWD'(addr); a.len = 8'(len);
        a.size = 3'(size); a.burst = 2'(burst);
        aw_q.push_back(a);
        err0 = (size > 3) || (burst == 3) ||
               (burst == 2 && !(len inside {1, 3, 7, 15}));
        bytes = 64'd1 << size;
        wsize = (longint'(len) + 1) * bytes;
        base  = addr - (addr % wsize);
        for (int k = 0; k < nbeats; k++) begin
            w.data = {$urandom, $urandom};
            w.strb = SW'($urandom);
            w.last = (k == nbeats - 1) && last_on_end;
            w_q.push_back(w);
            if (burst == 0)      ba = addr;
            else if (burst == 1) ba = addr + longint'(k) * bytes;
            else                 ba = base + ((addr - base + longint'(k) * bytes) % wsize);
            if (!err0) begin
                m.addr = AWD'(ba - (ba % SW));
                m.data = w.data;
                m.strb = w.strb;
                m.last = (k == nbeats - 1);
                exp_mem.push_back(m);
            end
        end
        mismatch = (last_on_end != ((nbeats - 1) == len));
        b.id = id;
        b.resp = (err0 || mismatch) ? 2'b10 : 2'b00;
        exp_b.push_back(b);
    endtask

    task automatic send_random();
        int size, burst, len, nb, mode;
        longint unsigned addr;
        bit lastf;
        size  = ($urandom_range(0, 9) == 0) ? 4 : $urandom_range(0, 3);
        burst = ($urandom_range(0, 11) == 0) ? 3 : $urandom_range(0, 2);
        if (burst == 2) begin
            case ($urandom_range(0, 4))
                0: len = 1; 1: len = 3; 2: len = 7; 3: len = 15;
                default: len = 2;
            endcase
        end else begin
            len = $urandom_range(0, 7);
        end
        addr = longint'($urandom_range(0, 8191));
        addr = addr - (addr % (64'd1 << size));
        mode = $urandom_range(0, 9);
        nb = len + 1;
        lastf = 1'b1;
        if (mode == 0 && len > 0) nb = $urandom_range(1, len);
        else if (mode == 1) lastf = 1'b0;
        send_burst(IDW'($urandom), addr, len, size, burst, nb, lastf);
    endtask

    task automatic wait_idle(input int budget, input string name);
        int n = 0;
        while ((aw_q.size() + w_q.size() + exp_mem.size() + exp_b.size()) != 0
               && n < budget) begin
            @(negedge aclk);
            n++;
        end
        if ((aw_q.size() + w_q.size() + exp_mem.size() + exp_b.size()) != 0)
            fail_now(name);
        repeat (3) @(negedge aclk);
    endtask

    task automatic do_reset(input int cycles);
        @(posedge aclk); #2;
        arst = 1'b1;
        aw_q.delete(); w_q.delete(); exp_mem.delete(); exp_b.delete();
        bus.aw_valid = 1'b0;
        bus.w_valid  = 1'b0;
        @(negedge aclk);
        check("reset_ctrl", {bus.aw_ready, bus.w_ready, bus.b_valid, mem_we,
                             bus.b_resp, bus.b_id, bus.b_user}, '0);
        check("reset_mem_addr", mem_addr, '0);
        check("reset_mem_wdata", mem_wdata, '0);
        check("reset_mem_wstrb", mem_wstrb, '0);
        repeat (cycles - 1) @(negedge aclk);
        @(posedge aclk); #2;
        arst = 1'b0;
        @(negedge aclk);
        check("post_reset_aw_ready", bus.aw_ready, 1);
        check("post_reset_b_valid", {bus.w_ready, bus.b_valid}, 0);
    endtask

    initial begin
        bus.aw_valid = 1'b0;
        bus.aw_id = '0; bus.aw_addr = '0; bus.aw_len = '0;
        bus.aw_size = '0; bus.aw_burst = '0;
        forever begin
            @(negedge aclk);
            if (bus.aw_valid && bus.aw_ready) void'(aw_q.pop_front());
            @(posedge aclk); #1;
            if (!arst && aw_q.size() > 0) begin
                bus.aw_valid = 1'b1;
                bus.aw_id    = aw_q[0].id;
                bus.aw_addr  = aw_q[0].addr;
                bus.aw_len   = aw_q[0].len;
                bus.aw_size  = aw_q[0].size;
                bus.aw_burst = aw_q[0].burst;
            end else begin
                bus.aw_valid = 1'b0;
            end
        end
    end

    initial begin
        bit popped;
        bus.w_valid = 1'b0; bus.w_data = '0; bus.w_strb = '0; bus.w_last = 1'b0;
        forever begin
            @(negedge aclk);
            popped = 1'b0;
            if (bus.w_valid && bus.w_ready) begin
                void'(w_q.pop_front());
                popped = 1'b1;
            end
            @(posedge aclk); #1;
            if (arst) begin
                bus.w_valid = 1'b0;
            end else if (!bus.w_valid || popped) begin
                if (w_q.size() > 0 && !w_hold && $urandom_range(0, 3) != 0) begin
                    bus.w_valid = 1'b1;
                    bus.w_data  = w_q[0].data;
                    bus.w_strb  = w_q[0].strb;
                    bus.w_last  = w_q[0].last;
                end else begin
                    bus.w_valid = 1'b0;
                end
            end
        end
    end

    initial begin
        bus.b_ready = 1'b0;
        forever begin
            @(posedge aclk); #1;
            bus.b_ready = !b_hold && ($urandom_range(0, 3) != 0);
        end
    end

    initial begin
        mem_t e;
        b_t   b;
        forever begin
            @(negedge aclk);
            if (!arst) begin
                if (mem_we) begin
                    if (exp_mem.size() == 0) begin
                        vectors++;
                        miscompares++;
                        $display("FAIL mem_we_unexpected: got write at %0h expected none",
                                 mem_addr);
                    end else begin
                        e = exp_mem.pop_front();
                        check("mem_addr", mem_addr, e.addr);
                        check("mem_wdata", mem_wdata, e.data);
                        check("mem_wstrb", mem_wstrb, e.strb);
                        if (e.last) check("b_valid_with_last_write", bus.b_valid, 1);
                    end
                end
                if (bus.b_valid && bus.b_ready) begin
                    if (exp_b.size() == 0) begin
                        vectors++;
                        miscompares++;
                        $display("FAIL b_unexpected: got id %0h expected no response",
                                 bus.b_id);
                    end else begin
                        b = exp_b.pop_front();
                        check("b_id", bus.b_id, b.id);
                        check("b_resp", bus.b_resp, b.resp);
                        check("b_user", bus.b_user, 0);
                    end
                end
            end
        end
    end

    initial begin
        int n;
        arst = 1'b1;
        do_reset(3);

        send_burst(4'd3, 64'h40, 0, 3, 1, 1, 1'b1);
        send_burst(4'd1, 64'h100, 3, 3, 1, 4, 1'b1);
        send_burst(4'd2, 64'h118, 3, 3, 2, 4, 1'b1);
        send_burst(4'd4, 64'h200, 3, 3, 1, 2, 1'b1);
        send_burst(4'd5, 64'h280, 1, 3, 1, 2, 1'b1);
        send_burst(4'd6, 64'h300, 1, 4, 1, 2, 1'b1);
        send_burst(4'd7, 64'hFF0, 3, 3, 1, 4, 1'b1);
        send_burst(4'd8, 64'h20, 2, 3, 2, 3, 1'b1);
        send_burst(4'd9, 64'h48, 2, 3, 1, 3, 1'b0);
        wait_idle(2000, "directed_done");

        w_hold = 1'b1;
        for (int i = 0; i < 5; i++) send_burst(IDW'(i), 64'h400 + 64'(i * 8), 0, 3, 1, 1, 1'b1);
        n = 0;
        while (aw_q.size() != 0 && n < 100) begin @(negedge aclk); n++; end
        if (aw_q.size() != 0) fail_now("aw_fill");
        @(negedge aclk);
        check("aw_ready_full", bus.aw_ready, 0);
        check("w_ready_first_burst", bus.w_ready, 1);
        w_hold = 1'b0;
        n = 0;
        while (!bus.aw_ready && n < 100) begin @(negedge aclk); n++; end
        check("aw_ready_after_pop", bus.aw_ready, 1);
        wait_idle(2000, "full_done");

        b_hold = 1'b1;
        @(posedge aclk); #2;
        send_burst(4'd5, 64'h500, 1, 3, 1, 2, 1'b1);
        n = 0;
        while (!bus.b_valid && n < 200) begin @(negedge aclk); n++; end
        if (!bus.b_valid) fail_now("b_stall_wait");
        for (int i = 0; i < 5; i++) begin
            @(negedge aclk);
            check("stall_b_valid", bus.b_valid, 1);
            check("stall_b_id", bus.b_id, 5);
            check("stall_b_resp", bus.b_resp, 0);
            check("stall_w_ready", bus.w_ready, 0);
        end
        b_hold = 1'b0;
        wait_idle(500, "stall_done");

        for (int i = 0; i < 40; i++) send_random();
        wait_idle(8000, "random_done");

        send_burst(4'd7, 64'h600, 7, 3, 1, 8, 1'b1);
        n = 0;
        while (exp_mem.size() > 5 && n < 500) begin @(negedge aclk); n++; end
        if (exp_mem.size() > 5) fail_now("midburst_wait");
        do_reset(2);
        repeat (10) @(negedge aclk);
        send_burst(4'd2, 64'h700, 1, 3, 1, 2, 1'b1);
        wait_idle(500, "recovery_done");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
